parallel: RTL and testbench
===========================

PARALLEL -- requirements
Module: parallel

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 a1..a4  input  8 each  lane operands A, unsigned.
REQ-005 b1..b4  input  8 each  lane operands B, unsigned.
REQ-006 c1..c4  input  8 each  lane operands C, unsigned.
REQ-007 d1..d4  input  8 each  lane operands D, unsigned.
REQ-008 e1..e4  input  8 each  lane operands E, unsigned.
REQ-009 f1..f4  input  8 each  lane operands F, unsigned.
REQ-010 g1..g4  output  8 each  sum results, gk = ak + bk.
REQ-011 h1..h4  output  8 each  difference results, hk = ck - dk.
REQ-012 i1..i4  output  8 each  product results, ik = ek * fk.
REQ-013 All outputs SHALL be driven directly from registers; there SHALL be no combinational input-to-output path.

Function
REQ-014 For each lane k = 1..4, the block SHALL compute all 12 results in parallel with no resource sharing between lanes or operations.
REQ-015 gk SHALL equal (ak + bk) mod 256; carry-out is discarded; no saturation.
REQ-016 hk SHALL equal (ck - dk) mod 256, two's-complement wrap when dk > ck; no borrow output.
REQ-017 ik SHALL equal the low 8 bits of the full 16-bit unsigned product ek * fk; upper 8 bits are discarded.
REQ-018 Latency SHALL be exactly 1 cycle: operands sampled at rising edge N appear on outputs after edge N and hold until edge N+1.
REQ-019 The block SHALL sample every cycle with no handshake; there is no valid/enable, and outputs update every cycle.
REQ-020 Lanes SHALL be independent: a change on any lane's operands SHALL affect only that lane's three outputs.
REQ-021 Boundary operands (0, 255) SHALL follow the wrap rules above with no special casing.

Reset
REQ-022 While rst_n = 0, all 12 output registers SHALL be 8'd0, asynchronously and independent of clk.
REQ-023 Reset assertion mid-operation SHALL clear outputs immediately and discard the in-flight result.
REQ-024 After rst_n deasserts, the first rising edge SHALL load results from the operands present at that edge.
REQ-025 Unknown (X) operands before first assignment SHALL NOT be required to produce defined outputs; outputs become defined one edge after operands are defined.

Verification
REQ-026 Reset: hold rst_n = 0 for any operand values -> all g, h, i = 0.
REQ-027 Vector 1: a=2,4,6,8 b=1,2,3,4 c=3,5,7,9 d=2,4,6,8 e=1,3,5,7 f=2,4,6,8 -> one edge later g=3,6,9,12 h=1,1,1,1 i=2,12,30,56.
REQ-028 Vector 2, applied the next cycle: a=3,5,7,9 b=2,1,2,3 c=4,6,8,8 d=1,3,5,7 e=2,4,6,8 f=2,3,5,7 -> g=5,6,9,12 h=3,3,3,1 i=4,12,30,56; Vector 1 results remain visible until that edge.
REQ-029 Wrap: a1=200 b1=100, c1=1 d1=2, e1=16 f1=17 -> g1=44, h1=255, i1=16; other lanes unaffected.
REQ-030 Extremes: a=b=c=e=f=255, d=0 in all lanes -> g=254, h=255, i=1 in every lane.
REQ-031 Reset mid-stream: apply Vector 1, pull rst_n low between edges -> outputs go to 0 before the next edge; release, apply Vector 2 -> Vector 2 results after the first edge.

Source files
------------

// File: rtl/parallel.sv
// Four independent lanes of add / subtract / multiply, each result registered (mod 256).
// Latency: 1 cycle; operands sampled on a rising edge appear on the outputs right after it.
// Backpressure: none; samples every cycle with no handshake, and outputs update every cycle.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset (clears all outputs to 0)
//   a1..a4, b1..b4      sum operands        -> g1..g4 = (ak + bk) mod 256
//   c1..c4, d1..d4      difference operands -> h1..h4 = (ck - dk) mod 256
//   e1..e4, f1..f4      product operands    -> i1..i4 = low byte of ek * fk
module parallel (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a1,
    input  logic [7:0] a2,
    input  logic [7:0] a3,
    input  logic [7:0] a4,
    input  logic [7:0] b1,
    input  logic [7:0] b2,
    input  logic [7:0] b3,
    input  logic [7:0] b4,
    input  logic [7:0] c1,
    input  logic [7:0] c2,
    input  logic [7:0] c3,
    input  logic [7:0] c4,
    input  logic [7:0] d1,
    input  logic [7:0] d2,
    input  logic [7:0] d3,
    input  logic [7:0] d4,
    input  logic [7:0] e1,
    input  logic [7:0] e2,
    input  logic [7:0] e3,
    input  logic [7:0] e4,
    input  logic [7:0] f1,
    input  logic [7:0] f2,
    input  logic [7:0] f3,
    input  logic [7:0] f4,
    output logic [7:0] g1,
    output logic [7:0] g2,
    output logic [7:0] g3,
    output logic [7:0] g4,
    output logic [7:0] h1,
    output logic [7:0] h2,
    output logic [7:0] h3,
    output logic [7:0] h4,
    output logic [7:0] i1,
    output logic [7:0] i2,
    output logic [7:0] i3,
    output logic [7:0] i4
);

    // Operands gathered per lane; index 0 is lane 1.
    logic [3:0][7:0] a_in, b_in, c_in, d_in, e_in, f_in;

    assign a_in = {a4, a3, a2, a1};
    assign b_in = {b4, b3, b2, b1};
    assign c_in = {c4, c3, c2, c1};
    assign d_in = {d4, d3, d2, d1};
    assign e_in = {e4, e3, e2, e1};
    assign f_in = {f4, f3, f2, f1};

    logic [3:0][7:0] g_d, g_q;
    logic [3:0][7:0] h_d, h_q;
    logic [3:0][7:0] i_d, i_q;

    // All arithmetic is evaluated in an 8-bit context, so carry, borrow and
    // the upper product byte fall away naturally: that is the wrap behaviour.
    // Each lane has its own adder, subtractor and multiplier; nothing is shared.
    always_comb begin
        g_d = '0;
        h_d = '0;
        i_d = '0;
        for (int k = 0; k < 4; k++) begin
            g_d[k] = a_in[k] + b_in[k];
            h_d[k] = c_in[k] - d_in[k];
            i_d[k] = e_in[k] * f_in[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q <= '0;
            h_q <= '0;
            i_q <= '0;
        end else begin
            g_q <= g_d;
            h_q <= h_d;
            i_q <= i_d;
        end
    end

    // Outputs come straight from the flops; there is no input-to-output path.
    assign g1 = g_q[0];
    assign g2 = g_q[1];
    assign g3 = g_q[2];
    assign g4 = g_q[3];
    assign h1 = h_q[0];
    assign h2 = h_q[1];
    assign h3 = h_q[2];
    assign h4 = h_q[3];
    assign i1 = i_q[0];
    assign i2 = i_q[1];
    assign i3 = i_q[2];
    assign i4 = i_q[3];

endmodule

// File: tb/tb_parallel.sv
// Directed testbench for parallel: reset, two back-to-back vectors, wrap, extremes, mid-stream reset.
// Latency: outputs are checked on the falling edge after the loading rising edge.
// Backpressure: none; inputs are driven on falling edges and held for a full cycle.
module tb_parallel;

    logic clk;
    logic rst_n;

    // Operands and results packed per lane; index 0 is lane 1.
    logic [3:0][7:0] a_v, b_v, c_v, d_v, e_v, f_v;
    logic [3:0][7:0] g_v, h_v, i_v;

    int n_checks;
    int n_errors;

    parallel dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a1(a_v[0]), .a2(a_v[1]), .a3(a_v[2]), .a4(a_v[3]),
        .b1(b_v[0]), .b2(b_v[1]), .b3(b_v[2]), .b4(b_v[3]),
        .c1(c_v[0]), .c2(c_v[1]), .c3(c_v[2]), .c4(c_v[3]),
        .d1(d_v[0]), .d2(d_v[1]), .d3(d_v[2]), .d4(d_v[3]),
        .e1(e_v[0]), .e2(e_v[1]), .e3(e_v[2]), .e4(e_v[3]),
        .f1(f_v[0]), .f2(f_v[1]), .f3(f_v[2]), .f4(f_v[3]),
        .g1(g_v[0]), .g2(g_v[1]), .g3(g_v[2]), .g4(g_v[3]),
        .h1(h_v[0]), .h2(h_v[1]), .h3(h_v[2]), .h4(h_v[3]),
        .i1(i_v[0]), .i2(i_v[1]), .i3(i_v[2]), .i4(i_v[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build a lane-packed word from lane 1..4 values.
    function automatic logic [3:0][7:0] pk(input logic [7:0] l1, input logic [7:0] l2,
                                           input logic [7:0] l3, input logic [7:0] l4);
        return {l4, l3, l2, l1};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Compare all twelve outputs against expected lane-packed values.
    task automatic check_all(input string tag, input logic [3:0][7:0] eg,
                             input logic [3:0][7:0] eh, input logic [3:0][7:0] ei);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s g%0d", tag, k + 1), g_v[k], eg[k]);
            check($sformatf("%s h%0d", tag, k + 1), h_v[k], eh[k]);
            check($sformatf("%s i%0d", tag, k + 1), i_v[k], ei[k]);
        end
    endtask

    task automatic drive(input logic [3:0][7:0] a, input logic [3:0][7:0] b,
                         input logic [3:0][7:0] c, input logic [3:0][7:0] d,
                         input logic [3:0][7:0] e, input logic [3:0][7:0] f);
        a_v = a; b_v = b; c_v = c; d_v = d; e_v = e; f_v = f;
    endtask

    task automatic drive_v1();
        drive(pk(2, 4, 6, 8), pk(1, 2, 3, 4), pk(3, 5, 7, 9),
              pk(2, 4, 6, 8), pk(1, 3, 5, 7), pk(2, 4, 6, 8));
    endtask

    task automatic drive_v2();
        drive(pk(3, 5, 7, 9), pk(2, 1, 2, 3), pk(4, 6, 8, 8),
              pk(1, 3, 5, 7), pk(2, 4, 6, 8), pk(2, 3, 5, 7));
    endtask

    logic [3:0][7:0] zero_w;
    logic [3:0][7:0] v1_g, v1_h, v1_i;
    logic [3:0][7:0] v2_g, v2_h, v2_i;

    initial begin
        n_checks = 0;
        n_errors = 0;
        zero_w = '0;
        v1_g = pk(3, 6, 9, 12);  v1_h = pk(1, 1, 1, 1);  v1_i = pk(2, 12, 30, 56);
        v2_g = pk(5, 6, 9, 12);  v2_h = pk(3, 3, 3, 1);  v2_i = pk(4, 12, 30, 56);

        // Reset held with arbitrary operands and a running clock: outputs stay 0.
        rst_n = 1'b0;
        drive(pk(9, 8, 7, 6), pk(200, 100, 50, 25), pk(1, 2, 3, 4),
              pk(5, 6, 7, 8), pk(255, 128, 64, 32), pk(3, 3, 3, 3));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset", zero_w, zero_w, zero_w);

        // Release between edges, then Vector 1 loads on the first edge.
        rst_n = 1'b1;
        drive_v1();
        @(negedge clk);
        check_all("vec1", v1_g, v1_h, v1_i);

        // Vector 2 applied mid-cycle: Vector 1 must stay visible until the edge.
        drive_v2();
        #2;
        check_all("vec1_hold", v1_g, v1_h, v1_i);
        @(negedge clk);
        check_all("vec2", v2_g, v2_h, v2_i);

        // Wrap cases on lane 1 only; lanes 2..4 keep Vector 2 operands.
        a_v[0] = 8'd200; b_v[0] = 8'd100;
        c_v[0] = 8'd1;   d_v[0] = 8'd2;
        e_v[0] = 8'd16;  f_v[0] = 8'd17;
        @(negedge clk);
        check_all("wrap", pk(44, 6, 9, 12), pk(255, 3, 3, 1), pk(16, 12, 30, 56));

        // Extremes in every lane.
        drive(pk(255, 255, 255, 255), pk(255, 255, 255, 255), pk(255, 255, 255, 255),
              pk(0, 0, 0, 0), pk(255, 255, 255, 255), pk(255, 255, 255, 255));
        @(negedge clk);
        check_all("extreme", pk(254, 254, 254, 254), pk(255, 255, 255, 255), pk(1, 1, 1, 1));

        // Mid-stream reset: Vector 1 loads, then reset between edges clears at once.
        drive_v1();
        @(posedge clk);
        #2;
        check_all("pre_rst", v1_g, v1_h, v1_i);
        rst_n = 1'b0;
        #1;
        check_all("mid_rst", zero_w, zero_w, zero_w);
        @(negedge clk);
        rst_n = 1'b1;
        drive_v2();
        #1;
        check_all("rst_rel", zero_w, zero_w, zero_w);
        @(negedge clk);
        check_all("post_rst", v2_g, v2_h, v2_i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
